// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with one outstanding request and a 2-entry {ins, pc} buffer.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirects raise sticky fetch_err and halt fetching.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, rpc;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] e0_q, e0_d, e1_q, e1_d, new_e;
    logic        ack, push, pop, bad, halt;

    assign imem_req  = state_q != IDLE;
    assign imem_addr = addr_q;
    assign ack       = imem_ack && imem_req;
    assign rpc       = {redirect_pc[31:2], 2'b00};
    assign ins_valid = cnt_q != 2'd0;
    assign ins       = ins_valid ? e0_q[63:32] : 32'h0;
    assign ins_pc    = ins_valid ? e0_q[31:0] : 32'h0;
    assign pop       = ins_valid && !stall && !redirect;
    assign push      = state_q == REQ && ack && !redirect;
    assign new_e     = {imem_rdata, pc_q};

`ifdef IFETCH_ALIGN_CHECK_EN
    logic halt_q;
    assign bad  = redirect && (redirect_pc[1:0] != 2'b00);
    assign halt = halt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else if (redirect) halt_q <= bad;
    end
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign bad  = 1'b0;
    assign halt = 1'b0;
`endif
    assign fetch_err = halt;

    always_comb begin
        cnt_d   = redirect ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
        pc_d    = redirect ? rpc : (push ? pc_q + 32'd4 : pc_q);
        state_d = state_q;
        if (bad) state_d = IDLE;
        else if (redirect) state_d = (state_q != IDLE && !ack) ? DROP : REQ;
        else if (state_q == IDLE) state_d = (!halt && cnt_d != 2'd2) ? REQ : IDLE;
        else if (ack) state_d = (state_q == DROP || cnt_d != 2'd2) ? REQ : IDLE;
        // address only moves when no request is in flight or the current one completes
        addr_d = (state_q == IDLE || ack) ? pc_d : addr_q;
        e0_d   = (pop && cnt_q == 2'd2) ? e1_q : ((push && (cnt_q == 2'd0 || pop)) ? new_e : e0_q);
        e1_d   = (push && cnt_q == 2'd1 && !pop) ? new_e : e1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            cnt_q   <= 2'd0;
            e0_q    <= 64'h0;
            e1_q    <= 64'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port imem_req  output  1  SHALL be the registered instruction-memory read request.
REQ-005 Port imem_addr  output  32  SHALL be the word-aligned fetch address (bits [1:0] = 0).
REQ-006 Port imem_ack  input  1  SHALL mark imem_rdata valid for the current request (same cycle as req allowed).
REQ-007 Port imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 Port stall  input  1  SHALL hold the head instruction (decode not ready).
REQ-009 Port redirect  input  1  SHALL request a flush and restart at redirect_pc (branch/jump resolved).
REQ-010 Port redirect_pc  input  32  SHALL be the restart address.
REQ-011 Port ins  output  32  SHALL be the head instruction presented to the decoder.
REQ-012 Port ins_pc  output  32  SHALL be the address of ins.
REQ-013 Port ins_valid  output  1  SHALL be high when ins/ins_pc are meaningful.
REQ-014 Port fetch_err  output  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-015 Block SHALL hold a 2-entry FIFO of {ins, pc}; ins/ins_pc/ins_valid SHALL come from the head entry, with ins = 32'h0000_0000 (NOP) and ins_pc = 0 when empty.
REQ-016 Pop SHALL occur when ins_valid && !stall && !redirect.
REQ-017 FSM states: IDLE (no request), REQ (imem_req = 1, address = fetch pc), DROP (imem_req = 1, response to be discarded).
REQ-018 At most one request SHALL be outstanding; imem_req and imem_addr SHALL stay stable from assertion until the imem_ack cycle.
REQ-019 IDLE->REQ when next FIFO count < 2 and not halted; REQ+ack without redirect: push {imem_rdata, pc}, pc += 4, stay REQ if next count < 2, else IDLE.
REQ-020 Pushed entry SHALL appear on ins_valid the cycle after imem_ack; back-to-back acks with no stall SHALL sustain one instruction per cycle.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; push when full SHALL be impossible by REQ-019.
REQ-022 Redirect SHALL empty the FIFO (ins_valid = 0 next cycle) and set fetch pc = redirect_pc; a pop in the same cycle SHALL be ignored.
REQ-023 Redirect in REQ without ack: go DROP; in DROP on ack: discard data, go REQ at redirect_pc; redirect while in DROP SHALL overwrite the target and remain in DROP.
REQ-024 Redirect in REQ coinciding with ack: data SHALL be discarded, next state REQ at redirect_pc.
REQ-025 Redirect in IDLE: next state REQ at redirect_pc.
REQ-026 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.

Reset
REQ-027 While rst_n = 0: state IDLE, imem_req = 0, imem_addr = RESET_PC, FIFO empty, ins_valid = 0, ins = 0, ins_pc = 0, fetch_err = 0.
REQ-028 First rising clk edge with rst_n = 1 SHALL enter REQ with imem_addr = RESET_PC.
REQ-029 Reset asserted mid-request SHALL abandon the request immediately; any later imem_ack is ignored until imem_req is reasserted.

Configuration
REQ-030 Macro IFETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 SHALL flush, set sticky fetch_err, and halt fetching (IDLE) until an aligned redirect, which clears fetch_err.
REQ-031 IFETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 0 and fetch_err SHALL be tied to 0.

Verification
REQ-032 Reset release, imem_ack same-cycle, rdata = 32'h0109_5020 -> imem_addr 0,4,8 on consecutive cycles; ins = 32'h0109_5020, ins_pc = 0 one cycle after first ack.
REQ-033 stall held for 5 cycles with continuous acks -> exactly 2 entries buffered, imem_req drops, no instruction lost or duplicated after stall releases.
REQ-034 imem_ack delayed 3 cycles, redirect to 32'h0000_0100 one cycle after request -> late response discarded, next imem_addr = 32'h0000_0100, ins_valid low until its ack.
REQ-035 redirect coincident with ack at pc 32'h0000_0008 -> that word never appears on ins; next fetch at redirect_pc.
REQ-036 fetch pc 32'hFFFF_FFFC, ack -> next imem_addr 32'h0000_0000.
REQ-037 IFETCH_ALIGN_CHECK_EN defined, redirect_pc 32'h0000_0102 -> fetch_err = 1, imem_req = 0; then redirect 32'h0000_0200 -> fetch_err = 0, fetch at 32'h0000_0200.
